// File: rtl/booth_seq_mult_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// Master drives start and operands; slave returns product, busy and done.
interface booth_seq_mult_if;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic        busy;
  logic        done;

  modport master (output start, multiplicand, multiplier, input product, busy, done);
  modport slave  (input start, multiplicand, multiplier, output product, busy, done);
endinterface

// File: rtl/booth_seq_mult.sv
// 8-bit ripple-carry adder feeding the Booth accumulator low byte.
module booth_rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end
endmodule

// Radix-2 Booth multiplier: signed 8x8 -> 16, one add/shift iteration per clock.
// Latency: product and a one-cycle done pulse 8 cycles after the accepting edge.
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped.
module booth_seq_mult (
  input  logic             clk,
  input  logic             rst,
  booth_seq_mult_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [8:0]  acc, mreg, mop, acc_add, acc_sel, acc_sh;
  logic [7:0]  qreg, q_sh, add_sum;
  logic        qm1, qm1_sh, sub, add_en, add_cout;
  logic [3:0]  cnt;
  logic [15:0] product_r;

  // {Q[0], q_m1} = 10 subtracts M (via ~M + 1), 01 adds M, otherwise A is kept.
  assign sub    = qreg[0] & ~qm1;
  assign add_en = ~qreg[0] & qm1;
  assign mop    = sub ? ~mreg : mreg;

  booth_rca8 u_add (
    .a    (acc[7:0]),
    .b    (mop[7:0]),
    .cin  (sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Ninth bit extends the adder so M = -128 cannot overflow the accumulator.
  assign acc_add = {acc[8] ^ mop[8] ^ add_cout, add_sum};
  assign acc_sel = (sub | add_en) ? acc_add : acc;
  assign acc_sh  = {acc_sel[8], acc_sel[8:1]};
  assign q_sh    = {acc_sel[0], qreg[7:1]};
  assign qm1_sh  = qreg[0];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == 4'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      qreg      <= '0;
      qm1       <= 1'b0;
      mreg      <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc  <= '0;
            qreg <= bus.multiplier;
            qm1  <= 1'b0;
            mreg <= {bus.multiplicand[7], bus.multiplicand};
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= acc_sh;
          qreg <= q_sh;
          qm1  <= qm1_sh;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd7) product_r <= {acc_sh[7:0], q_sh};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_r;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult: reset, latency, signed corners, protocol, strided sweep.
module tb_booth_seq_mult;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_seq_mult_if bif ();

  booth_seq_mult dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0]  cm   [6] = '{8'd127, 8'h80, 8'h80, 8'hFF, 8'd0, 8'd5};
  logic [7:0]  cq   [6] = '{8'd127, 8'd1, 8'h80, 8'hFF, 8'hB3, 8'hFD};
  logic [15:0] cexp [6] = '{16'h3F01, 16'hFF80, 16'h4000, 16'h0001, 16'h0000, 16'hFFF1};

  // Called just after an edge with the DUT in IDLE; returns one edge after the done pulse.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                        output logic [15:0] p, output int lat);
    bif.start        = 1'b1;
    bif.multiplicand = m;
    bif.multiplier   = q;
    @(posedge clk); #1;
    bif.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    p = bif.product;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bif.start = 1'b0;
    bif.multiplicand = '0;
    bif.multiplier = '0;
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bif.product !== 16'h0000) begin
      errors++; $display("FAIL reset_product: got %h want 0000", bif.product);
    end
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", bif.busy);
    end
    checks++;
    if (bif.done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", bif.done);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bif.product !== 16'h0000 || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: got p=%h busy=%b done=%b want 0000/0/0",
                 i, bif.product, bif.busy, bif.done);
      end
    end
  endtask

  task automatic test_basic();
    int bad;
    bif.start = 1'b1;
    bif.multiplicand = 8'd3;
    bif.multiplier = 8'd5;
    @(posedge clk); #1;
    bif.start = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (bif.busy !== 1'b1 || bif.done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_busy_window: %0d bad cycles want 0", bad);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b1) begin
      errors++; $display("FAIL basic_done_edge: got busy=%b done=%b want 0/1", bif.busy, bif.done);
    end
    checks++;
    if (bif.product !== 16'h000F) begin
      errors++; $display("FAIL basic_product: got %h want 000F", bif.product);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_fall: got busy=%b done=%b want 0/0", bif.busy, bif.done);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.product !== 16'h000F) begin
      errors++; $display("FAIL basic_hold: got %h want 000F", bif.product);
    end
  endtask

  task automatic test_corners();
    logic [15:0] p;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(cm[i], cq[i], p, lat);
      checks++;
      if (p !== cexp[i] || lat != 8) begin
        errors++;
        $display("FAIL corner_%0d %h*%h: got %h lat=%0d want %h lat=8", i, cm[i], cq[i], p, lat, cexp[i]);
      end
    end
  endtask

  task automatic test_protocol();
    int lat;
    bif.start = 1'b1;
    bif.multiplicand = 8'd11;
    bif.multiplier = 8'd13;
    @(posedge clk); #1;
    bif.multiplicand = 8'd99;
    bif.multiplier = 8'hCE;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (bif.product !== 16'h008F || lat != 8) begin
      errors++; $display("FAIL protocol_ignore: got %h lat=%0d want 008F lat=8", bif.product, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      errors++; $display("FAIL protocol_done_start: got busy=%b done=%b want 0/0", bif.busy, bif.done);
    end
    bif.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bif.busy !== 1'b0 || bif.product !== 16'h008F) begin
      errors++; $display("FAIL protocol_idle: got busy=%b p=%h want 0/008F", bif.busy, bif.product);
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int overlap;
    overlap = 0;
    bif.start = 1'b1;
    bif.multiplicand = 8'd7;
    bif.multiplier = 8'd8;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (bif.busy === 1'b1 && bif.done === 1'b1) overlap++;
      if (bif.done === 1'b1) begin
        checks++;
        if (bif.product !== 16'((7 + pulses.size()) * 8)) begin
          errors++;
          $display("FAIL b2b_product_%0d: got %h want %h", pulses.size(), bif.product,
                   16'((7 + pulses.size()) * 8));
        end
        pulses.push_back(c);
        bif.multiplicand = 8'(7 + pulses.size());
      end
    end
    bif.start = 1'b0;
    checks++;
    if (overlap != 0) begin
      errors++; $display("FAIL b2b_overlap: got %0d cycles want 0", overlap);
    end
    checks++;
    if (pulses.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d pulses want 4", pulses.size());
    end else begin
      checks++;
      if (pulses[0] != 9 || pulses[1] != 19 || pulses[2] != 29 || pulses[3] != 39) begin
        errors++;
        $display("FAIL b2b_period: got %0d %0d %0d %0d want 9 19 29 39",
                 pulses[0], pulses[1], pulses[2], pulses[3]);
      end
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat;
    int seen;
    bif.start = 1'b1;
    bif.multiplicand = 8'd100;
    bif.multiplier = 8'd100;
    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.product !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_state: got busy=%b done=%b p=%h want 0/0/0000",
               bif.busy, bif.done, bif.product);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bif.done !== 1'b0 || bif.busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen);
    end
    run_op(8'd7, 8'hF7, p, lat);
    checks++;
    if (p !== 16'hFFC1 || lat != 8) begin
      errors++; $display("FAIL midreset_next: got %h lat=%0d want FFC1 lat=8", p, lat);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] p;
    logic [15:0] expv;
    int lat;
    for (int mi = -128; mi < 128; mi += 5) begin
      for (int qi = -128; qi < 128; qi += 5) begin
        run_op(8'(mi), 8'(qi), p, lat);
        expv = 16'(mi * qi);
        checks++;
        if (p !== expv || lat != 8) begin
          errors++;
          $display("FAIL sweep %0d*%0d: got %h lat=%0d want %h lat=8", mi, qi, p, lat, expv);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_corners();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
